// File: rtl/mac_stream_engine.sv
// Streaming multiply-accumulate engine: dot product or Horner evaluation over a
// job of len operand beats, with valid/ready handshakes on input and result.
module mac_stream_engine #(
  parameter int DATA_W   = 8,
  parameter int ACC_W    = 24,
  parameter int LEN_W    = 8,
  parameter bit SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  result,
  output logic              overflow,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int FW = ACC_W + DATA_W + 1;

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [LEN_W-1:0]   count_reg, count_next;
  logic               mode_reg, mode_next;
  logic               ovf_reg, ovf_next;
  logic               in_ready_reg, out_valid_reg, busy_reg;

  logic [FW-1:0]      acc_ext, a_ext, b_ext, full;
  logic               beat_ovf;
  logic [ACC_W-1:0]   beat_val;
  logic               beat_fire;

  // Full-precision datapath; the top bits only exist to detect overflow.
  assign acc_ext  = {{(FW-ACC_W){1'b0}}, acc_reg};
  assign a_ext    = {{(FW-DATA_W){1'b0}}, in_a};
  assign b_ext    = {{(FW-DATA_W){1'b0}}, in_b};
  assign full     = mode_reg ? (acc_ext * b_ext + a_ext) : (acc_ext + a_ext * b_ext);
  assign beat_ovf = |full[FW-1:ACC_W];
  assign beat_val = (beat_ovf && SATURATE) ? {ACC_W{1'b1}} : full[ACC_W-1:0];
  assign beat_fire = in_valid && in_ready_reg;

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    len_next   = len_reg;
    count_next = count_reg;
    mode_next  = mode_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          mode_next  = mode;
          len_next   = len;
          acc_next   = '0;
          count_next = '0;
          ovf_next   = 1'b0;
          state_next = (len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (beat_fire) begin
          acc_next   = beat_val;
          ovf_next   = ovf_reg | beat_ovf;
          count_next = count_reg + LEN_W'(1);
          if (count_next == len_reg) state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so no output decodes state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      len_reg       <= '0;
      count_reg     <= '0;
      mode_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      len_reg       <= len_next;
      count_reg     <= count_next;
      mode_reg      <= mode_next;
      ovf_reg       <= ovf_next;
      in_ready_reg  <= (state_next == RUN);
      out_valid_reg <= (state_next == DONE);
      busy_reg      <= (state_next != IDLE);
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign result    = acc_reg;
  assign overflow  = ovf_reg;

endmodule

// File: tb/tb_mac_stream_engine.sv
// Scoreboard bench: three engines (24-bit sat, 16-bit sat, 16-bit wrap) share one
// stimulus stream; an arithmetic reference model predicts each job's result.
module tb_mac_stream_engine;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [7:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = '0;
  logic [7:0]  in_b = '0;
  logic        out_ready = 1'b0;

  logic [2:0]  ir, ovld, ofl, bsy;
  logic [23:0] res0;
  logic [15:0] res1, res2;

  int checks = 0;
  int errors = 0;

  typedef struct {longint r; bit o;} exp_t;
  exp_t q[3][$];

  int a_arr[256];
  int b_arr[256];

  always #5 clk = ~clk;

  mac_stream_engine #(.DATA_W(8), .ACC_W(24), .LEN_W(8), .SATURATE(1'b1)) u0 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len),
    .in_valid(in_valid), .in_ready(ir[0]), .in_a(in_a), .in_b(in_b),
    .out_valid(ovld[0]), .out_ready(out_ready), .result(res0),
    .overflow(ofl[0]), .busy(bsy[0]));

  mac_stream_engine #(.DATA_W(8), .ACC_W(16), .LEN_W(8), .SATURATE(1'b1)) u1 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len),
    .in_valid(in_valid), .in_ready(ir[1]), .in_a(in_a), .in_b(in_b),
    .out_valid(ovld[1]), .out_ready(out_ready), .result(res1),
    .overflow(ofl[1]), .busy(bsy[1]));

  mac_stream_engine #(.DATA_W(8), .ACC_W(16), .LEN_W(8), .SATURATE(1'b0)) u2 (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len),
    .in_valid(in_valid), .in_ready(ir[2]), .in_a(in_a), .in_b(in_b),
    .out_valid(ovld[2]), .out_ready(out_ready), .result(res2),
    .overflow(ofl[2]), .busy(bsy[2]));

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic over the first n beats of a_arr/b_arr.
  function automatic void ref_model(input bit md, input int n, input int accw,
                                    input bit sat, output longint r, output bit o);
    longint acc, maxv, full;
    acc  = 0;
    maxv = (longint'(1) << accw) - 1;
    o    = 1'b0;
    for (int i = 0; i < n; i++) begin
      full = md ? (acc * b_arr[i] + a_arr[i]) : (acc + a_arr[i] * b_arr[i]);
      if (full > maxv) begin
        o   = 1'b1;
        acc = sat ? maxv : (full & maxv);
      end else begin
        acc = full;
      end
    end
    r = acc;
  endfunction

  task automatic mon(input int k, input longint res, input logic vld, input logic of);
    exp_t e;
    if (vld && out_ready) begin
      if (q[k].size() == 0) begin
        chk($sformatf("unexpected_result_dut%0d", k), 1, 0);
      end else begin
        e = q[k].pop_front();
        chk($sformatf("result_dut%0d", k), res, e.r);
        chk($sformatf("overflow_dut%0d", k), of, e.o);
        $display("job dut%0d result=%0d overflow=%0d", k, res, of);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      mon(0, res0, ovld[0], ofl[0]);
      mon(1, res1, ovld[1], ofl[1]);
      mon(2, res2, ovld[2], ofl[2]);
    end
  end

  task automatic push_expected(input bit md, input int n);
    exp_t e;
    longint r;
    bit o;
    ref_model(md, n, 24, 1'b1, r, o); e.r = r; e.o = o; q[0].push_back(e);
    ref_model(md, n, 16, 1'b1, r, o); e.r = r; e.o = o; q[1].push_back(e);
    ref_model(md, n, 16, 1'b0, r, o); e.r = r; e.o = o; q[2].push_back(e);
  endtask

  task automatic run_job(input bit md, input int n, input int bubble_pct,
                         input bit alt, input int hold, input bit poke);
    int     i, guard;
    bit     took;
    longint r, rf;
    bit     o, of;
    ref_model(md, n, 24, 1'b1, rf, of);
    push_expected(md, n);
    start = 1'b1; mode = md; len = 8'(n);
    @(posedge clk); #1;
    start = 1'b0; mode = 1'($urandom); len = 8'($urandom);
    chk("busy_after_start", bsy, 3'b111);
    chk("in_ready_after_start", ir[0], longint'(n != 0));
    i = 0; guard = 0;
    while (i < n && guard < 2000) begin
      in_a = 8'(a_arr[i]);
      in_b = 8'(b_arr[i]);
      in_valid = alt ? (guard % 2 == 0) : ($urandom_range(99) >= bubble_pct);
      start = poke && $urandom_range(1) == 1;
      @(negedge clk);
      took = in_valid && ir[0];
      @(posedge clk); #1;
      start = 1'b0;
      if (took) begin
        i++;
        ref_model(md, i, 24, 1'b1, r, o);
        chk("acc_step", res0, r);
      end
      guard++;
    end
    if (i < n) chk("beat_timeout", i, n);
    in_valid = 1'b0;
    chk("out_valid_latency", ovld, 3'b111);
    repeat (hold) begin
      start = poke;
      @(posedge clk); #1;
      chk("hold_valid", ovld, 3'b111);
      chk("hold_result", res0, rf);
    end
    out_ready = 1'b1;
    start = poke;
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    chk("busy_after_handshake", bsy, 0);
    chk("valid_after_handshake", ovld, 0);
    $display("job mode=%0d len=%0d expected=%0d ovf=%0d", md, n, rf, of);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_ready"}, ir, 0);
    chk({tag, "_out_valid"}, ovld, 0);
    chk({tag, "_busy"}, bsy, 0);
    chk({tag, "_overflow"}, ofl, 0);
    chk({tag, "_result0"}, res0, 0);
    chk({tag, "_result1"}, res1, 0);
    chk({tag, "_result2"}, res2, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check_all_zero("post_reset");

    // dot product 1*4+2*5+3*6 = 32
    a_arr[0] = 1; b_arr[0] = 4; a_arr[1] = 2; b_arr[1] = 5; a_arr[2] = 3; b_arr[2] = 6;
    run_job(1'b0, 3, 0, 1'b0, 0, 1'b0);

    // Horner 2,3,1 at x=5 -> 2, 13, 66
    a_arr[0] = 2; a_arr[1] = 3; a_arr[2] = 1;
    for (int i = 0; i < 3; i++) b_arr[i] = 5;
    run_job(1'b1, 3, 0, 1'b0, 0, 1'b0);

    // two 255*255 beats overflow the 16-bit engines
    for (int i = 0; i < 2; i++) begin a_arr[i] = 255; b_arr[i] = 255; end
    run_job(1'b0, 2, 0, 1'b0, 0, 1'b0);

    a_arr[0] = 1; b_arr[0] = 1;
    run_job(1'b0, 1, 0, 1'b0, 0, 1'b0);
    chk("clean_job_overflow", ofl, 0);

    // alternating bubbles, stalled collector and ignored start pulses -> 30
    for (int i = 0; i < 4; i++) begin a_arr[i] = i + 1; b_arr[i] = i + 1; end
    run_job(1'b0, 4, 0, 1'b1, 5, 1'b1);

    run_job(1'b0, 0, 0, 1'b0, 1, 1'b0);

    // reset part-way through a job discards it
    for (int i = 0; i < 4; i++) begin a_arr[i] = 9; b_arr[i] = 9; end
    start = 1'b1; mode = 1'b0; len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    a_arr[0] = 7; b_arr[0] = 3;
    run_job(1'b0, 1, 0, 1'b0, 0, 1'b0);

    for (int j = 0; j < 30; j++) begin
      int n;
      bit md;
      md = 1'($urandom);
      n = ($urandom_range(9) == 0) ? $urandom_range(40) : $urandom_range(12);
      for (int i = 0; i < n; i++) begin
        a_arr[i] = $urandom_range(255);
        b_arr[i] = md ? $urandom_range(($urandom_range(1) == 1) ? 255 : 4) : $urandom_range(255);
      end
      run_job(md, n, 30, 1'b0, $urandom_range(3), 1'($urandom));
    end

    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) chk($sformatf("pending_dut%0d", k), q[k].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
